ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Sits directly downstream of ps2_keyboard. Pops scan-code bytes from that block's receive FIFO through its ready/nextdata_n interface.
- Decodes make, break (F0) and extended (E0) sequences and tracks the single most-recent held key.
- Registered outputs are the key's scan code, its ASCII value and a BCD press count. These feed the seg display stage.

Parameters:
- COUNT_REPEAT, 0, 1 = typematic repeats of the held key increment press count; 0 = they do not.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- kb_ready  input  1  ps2_keyboard FIFO non-empty.
- kb_data  input  8  byte at FIFO head; valid while kb_ready=1.
- kb_overflow  input  1  ps2_keyboard FIFO overflow flag.
- kb_nextdata_n  output  1  active-low pop strobe, one cycle wide.
- key_down  output  1  a key is currently held.
- key_ext  output  1  held/last key was E0-prefixed.
- key_code  output  8  last make code received.
- key_ascii  output  8  lowercase ASCII of key_code; 0x00 if unmapped or key_ext=1.
- press_cnt  output  8  two BCD digits [7:4] tens, [3:0] units, 00..99.
- ovf_sticky  output  1  set when kb_overflow=1 is sampled; cleared only by rst.

Behaviour:
- Reset (rst=1 at edge): kb_nextdata_n=1, key_down=0, key_ext=0, key_code=0x00, key_ascii=0x00, press_cnt=0x00, ovf_sticky=0.
- Reset also clears the internal flags brk_pend and ext_pend and returns the FSM to IDLE.
- Reset mid-sequence (e.g. after F0) discards the partial sequence.
- FSM states: IDLE, POP, GAP.
- IDLE: if kb_ready=1, capture kb_data into byte_r and go to POP. Otherwise stay in IDLE.
- POP: kb_nextdata_n=0 for exactly this cycle. Classify byte_r and update outputs at the end of POP. Go to GAP.
- GAP: kb_nextdata_n=1. Wait one cycle so kb_ready and kb_data can settle, then go to IDLE.
- Throughput is at most one byte per 3 cycles. Latency is 2 cycles from kb_ready sampled high to updated outputs.
- kb_nextdata_n is never asserted while kb_ready=0 in the IDLE cycle.
- Classification in POP:
  - byte_r=E0: set ext_pend.
  - byte_r=F0: set brk_pend.
  - Other byte with brk_pend=1 (break): if key_down=1 and byte_r==key_code and ext_pend==key_ext, clear key_down. A break of a non-held key is ignored. Clear brk_pend and ext_pend in both cases.
  - Other byte with brk_pend=0 (make), repeat case: key_down=1, byte_r==key_code and ext_pend==key_ext. Outputs are unchanged; press_cnt increments only if COUNT_REPEAT=1.
  - Other byte with brk_pend=0 (make), new key: key_code=byte_r, key_ext=ext_pend, key_down=1, press_cnt increments.
  - A make always clears ext_pend.
- press_cnt increment is BCD: units 9 -> 0 with tens+1; 99 -> 00 (wrap).
- key_ascii is registered, updated in the same cycle as key_code, and drawn from a combinational LUT on byte_r.
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Any other code gives 0x00.
- key_code, key_ascii and key_ext hold their values after a break; only key_down falls.
- ovf_sticky: sampled every cycle, independent of the FSM.

Test Plan:
- Reset, then feed bytes 1C, F0, 1C -> after 1C: key_code=1C, key_ascii=0x61, key_down=1, press_cnt=01. After the break: key_down=0, key_code=1C.
- Feed 1C, 1C, 1C (typematic) with COUNT_REPEAT=0 -> press_cnt=01. Same stimulus with COUNT_REPEAT=1 -> press_cnt=03.
- Feed E0, 75, E0, F0, 75 -> key_ext=1, key_code=75, key_ascii=00, press_cnt=01, then key_down=0.
- Feed 1C then 32 (second key while first held), then F0 1C -> key_code=32, key_ascii=0x62, press_cnt=02. The break for 1C is ignored, so key_down stays 1.
- Feed 100 distinct make/break pairs -> press_cnt reads 0x99 after 99 presses and 0x00 after 100. Nibbles never exceed 9.
- Hold kb_ready=1 with back-to-back bytes -> kb_nextdata_n is low exactly 1 cycle in every 3. Assert rst after an F0 -> all outputs zero. A following 1C is treated as a make, press_cnt=01. A kb_overflow pulse sets ovf_sticky=1 until reset.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// Pops scan-code bytes from the ps2_keyboard FIFO, decodes make/break/E0 sequences and
// tracks the most recent held key with its ASCII value and a BCD press count.
module ps2_key_tracker #(
    parameter bit COUNT_REPEAT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kb_ready,
    input  logic [7:0] kb_data,
    input  logic       kb_overflow,
    output logic       kb_nextdata_n,
    output logic       key_down,
    output logic       key_ext,
    output logic [7:0] key_code,
    output logic [7:0] key_ascii,
    output logic [7:0] press_cnt,
    output logic       ovf_sticky
);

    typedef enum logic [1:0] {StIdle, StPop, StGap} state_e;

    state_e     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       brk_pend_q, brk_pend_d;
    logic       ext_pend_q, ext_pend_d;
    logic       key_down_q, key_down_d;
    logic       key_ext_q, key_ext_d;
    logic [7:0] key_code_q, key_code_d;
    logic [7:0] key_ascii_q, key_ascii_d;
    logic [7:0] press_cnt_q, press_cnt_d;
    logic       ovf_q;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = (v[7:4] == 4'd9) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] ascii_lut(input logic [7:0] code);
        logic [7:0] a;
        unique case (code)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    logic same_key;
    assign same_key = key_down_q && (byte_q == key_code_q) && (ext_pend_q == key_ext_q);

    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        brk_pend_d    = brk_pend_q;
        ext_pend_d    = ext_pend_q;
        key_down_d    = key_down_q;
        key_ext_d     = key_ext_q;
        key_code_d    = key_code_q;
        key_ascii_d   = key_ascii_q;
        press_cnt_d   = press_cnt_q;
        kb_nextdata_n = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (kb_ready) begin
                    byte_d  = kb_data;
                    state_d = StPop;
                end
            end
            StPop: begin
                kb_nextdata_n = 1'b0;
                state_d       = StGap;
                if (byte_q == 8'hE0) begin
                    ext_pend_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_pend_d = 1'b1;
                end else if (brk_pend_q) begin
                    // A break for anything other than the held key is dropped.
                    if (same_key) key_down_d = 1'b0;
                    brk_pend_d = 1'b0;
                    ext_pend_d = 1'b0;
                end else begin
                    ext_pend_d = 1'b0;
                    if (same_key) begin
                        if (COUNT_REPEAT) press_cnt_d = bcd_inc(press_cnt_q);
                    end else begin
                        key_code_d  = byte_q;
                        key_ext_d   = ext_pend_q;
                        key_ascii_d = ext_pend_q ? 8'h00 : ascii_lut(byte_q);
                        key_down_d  = 1'b1;
                        press_cnt_d = bcd_inc(press_cnt_q);
                    end
                end
            end
            StGap: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            byte_q      <= 8'h00;
            brk_pend_q  <= 1'b0;
            ext_pend_q  <= 1'b0;
            key_down_q  <= 1'b0;
            key_ext_q   <= 1'b0;
            key_code_q  <= 8'h00;
            key_ascii_q <= 8'h00;
            press_cnt_q <= 8'h00;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            brk_pend_q  <= brk_pend_d;
            ext_pend_q  <= ext_pend_d;
            key_down_q  <= key_down_d;
            key_ext_q   <= key_ext_d;
            key_code_q  <= key_code_d;
            key_ascii_q <= key_ascii_d;
            press_cnt_q <= press_cnt_d;
            if (kb_overflow) ovf_q <= 1'b1;
        end
    end

    assign key_down   = key_down_q;
    assign key_ext    = key_ext_q;
    assign key_code   = key_code_q;
    assign key_ascii  = key_ascii_q;
    assign press_cnt  = press_cnt_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker; dut0 has COUNT_REPEAT=0, dut1 has COUNT_REPEAT=1,
// both fed the same byte stream.
module tb_ps2_key_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kb_ready = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_overflow = 1'b0;

    logic       nd0, down0, ext0, ovf0, nd1, down1, ext1, ovf1;
    logic [7:0] code0, ascii0, cnt0, code1, ascii1, cnt1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ps2_key_tracker #(.COUNT_REPEAT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .kb_ready(kb_ready), .kb_data(kb_data),
        .kb_overflow(kb_overflow), .kb_nextdata_n(nd0), .key_down(down0), .key_ext(ext0),
        .key_code(code0), .key_ascii(ascii0), .press_cnt(cnt0), .ovf_sticky(ovf0)
    );

    ps2_key_tracker #(.COUNT_REPEAT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .kb_ready(kb_ready), .kb_data(kb_data),
        .kb_overflow(kb_overflow), .kb_nextdata_n(nd1), .key_down(down1), .key_ext(ext1),
        .key_code(code1), .key_ascii(ascii1), .press_cnt(cnt1), .ovf_sticky(ovf1)
    );

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] tens, units;
        tens  = 4'((n % 100) / 10);
        units = 4'(n % 10);
        return {tens, units};
    endfunction

    task automatic reset_dut();
        kb_ready = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Presents one byte, expects the pop one cycle later, returns in IDLE with outputs updated.
    task automatic send_byte(input logic [7:0] b);
        bit popped;
        int waited;
        popped = 1'b0;
        waited = -1;
        @(negedge clk);
        kb_data  = b;
        kb_ready = 1'b1;
        for (int i = 0; i < 8 && !popped; i++) begin
            @(posedge clk); #1;
            if (nd0 === 1'b0) begin popped = 1'b1; waited = i; end
        end
        vectors++;
        if (!popped || waited != 0) begin
            miscompares++;
            $display("FAIL pop_latency byte=%h popped=%0b waited=%0d, required pop 1 cycle after ready",
                     b, popped, waited);
        end
        if (popped) begin @(posedge clk); #1; end
        kb_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_dut();
        #1;
        vectors++;
        if ({nd0, down0, ext0, code0, ascii0, cnt0, ovf0} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset0 got nd=%b dn=%b ext=%b code=%h ascii=%h cnt=%h ovf=%b, required 1 0 0 00 00 00 0",
                     nd0, down0, ext0, code0, ascii0, cnt0, ovf0);
        end
        vectors++;
        if ({nd1, down1, ext1, code1, ascii1, cnt1, ovf1} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset1 got nd=%b dn=%b ext=%b code=%h ascii=%h cnt=%h ovf=%b, required 1 0 0 00 00 00 0",
                     nd1, down1, ext1, code1, ascii1, cnt1, ovf1);
        end
        // With nothing in the FIFO the pop strobe must stay idle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (nd0 !== 1'b1) begin
                miscompares++;
                $display("FAIL idle_no_pop cycle=%0d got nd=%b, required 1", i, nd0);
            end
        end
    endtask

    task automatic test_make_break();
        reset_dut();
        send_byte(8'h1C);
        vectors++;
        if ({down0, ext0, code0, ascii0, cnt0} !== {1'b1, 1'b0, 8'h1C, 8'h61, 8'h01}) begin
            miscompares++;
            $display("FAIL make_1c got dn=%b ext=%b code=%h ascii=%h cnt=%h, required 1 0 1c 61 01",
                     down0, ext0, code0, ascii0, cnt0);
        end
        send_byte(8'hF0);
        vectors++;
        if (down0 !== 1'b1) begin
            miscompares++;
            $display("FAIL f0_alone got dn=%b, required 1", down0);
        end
        send_byte(8'h1C);
        vectors++;
        if ({down0, code0, ascii0, cnt0} !== {1'b0, 8'h1C, 8'h61, 8'h01}) begin
            miscompares++;
            $display("FAIL break_1c got dn=%b code=%h ascii=%h cnt=%h, required 0 1c 61 01",
                     down0, code0, ascii0, cnt0);
        end
    endtask

    task automatic test_typematic();
        reset_dut();
        for (int i = 0; i < 3; i++) send_byte(8'h1C);
        vectors++;
        if ({down0, code0, cnt0} !== {1'b1, 8'h1C, 8'h01}) begin
            miscompares++;
            $display("FAIL typematic_norep got dn=%b code=%h cnt=%h, required 1 1c 01", down0, code0, cnt0);
        end
        vectors++;
        if ({down1, code1, cnt1} !== {1'b1, 8'h1C, 8'h03}) begin
            miscompares++;
            $display("FAIL typematic_rep got dn=%b code=%h cnt=%h, required 1 1c 03", down1, code1, cnt1);
        end
    endtask

    task automatic test_extended();
        reset_dut();
        send_byte(8'hE0);
        send_byte(8'h75);
        vectors++;
        if ({down0, ext0, code0, ascii0, cnt0} !== {1'b1, 1'b1, 8'h75, 8'h00, 8'h01}) begin
            miscompares++;
            $display("FAIL ext_make got dn=%b ext=%b code=%h ascii=%h cnt=%h, required 1 1 75 00 01",
                     down0, ext0, code0, ascii0, cnt0);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        vectors++;
        if ({down0, ext0, code0, cnt0} !== {1'b0, 1'b1, 8'h75, 8'h01}) begin
            miscompares++;
            $display("FAIL ext_break got dn=%b ext=%b code=%h cnt=%h, required 0 1 75 01",
                     down0, ext0, code0, cnt0);
        end
    endtask

    task automatic test_second_key();
        reset_dut();
        send_byte(8'h1C);
        send_byte(8'h32);
        vectors++;
        if ({down0, code0, ascii0, cnt0} !== {1'b1, 8'h32, 8'h62, 8'h02}) begin
            miscompares++;
            $display("FAIL second_key got dn=%b code=%h ascii=%h cnt=%h, required 1 32 62 02",
                     down0, code0, ascii0, cnt0);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        vectors++;
        if ({down0, code0} !== {1'b1, 8'h32}) begin
            miscompares++;
            $display("FAIL stale_break got dn=%b code=%h, required 1 32", down0, code0);
        end
        // Extended break of a non-extended held key must not release it.
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h32);
        vectors++;
        if (down0 !== 1'b1) begin
            miscompares++;
            $display("FAIL ext_mismatch_break got dn=%b, required 1", down0);
        end
        send_byte(8'hF0);
        send_byte(8'h32);
        vectors++;
        if ({down0, ext0} !== {1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL release_32 got dn=%b ext=%b, required 0 0", down0, ext0);
        end
    endtask

    task automatic test_bcd_wrap();
        reset_dut();
        for (int p = 1; p <= 100; p++) begin
            send_byte(8'h1C);
            send_byte(8'hF0);
            send_byte(8'h1C);
            vectors++;
            if (cnt0 !== to_bcd(p) || cnt0[7:4] > 4'd9 || cnt0[3:0] > 4'd9) begin
                miscompares++;
                $display("FAIL bcd_count press=%0d got cnt=%h, required %h", p, cnt0, to_bcd(p));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int lows, last, bad_gap, first;
        reset_dut();
        q = '{8'h2A, 8'hF0, 8'h2A, 8'h35};
        lows = 0; last = -1; bad_gap = 0; first = -1;
        @(negedge clk);
        kb_data  = q[0];
        kb_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (nd0 === 1'b0) begin
                lows++;
                if (first < 0) first = i;
                if (last >= 0 && i - last != 3) bad_gap++;
                last = i;
                void'(q.pop_front());
            end
            kb_ready = (q.size() != 0);
            if (q.size() != 0) kb_data = q[0];
        end
        vectors++;
        if (lows != 4 || bad_gap != 0 || first != 1) begin
            miscompares++;
            $display("FAIL b2b_strobe got lows=%0d bad_gaps=%0d first=%0d, required 4 0 1",
                     lows, bad_gap, first);
        end
        vectors++;
        if ({down0, code0, ascii0, cnt0} !== {1'b1, 8'h35, 8'h79, 8'h02}) begin
            miscompares++;
            $display("FAIL b2b_result got dn=%b code=%h ascii=%h cnt=%h, required 1 35 79 02",
                     down0, code0, ascii0, cnt0);
        end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        send_byte(8'h1C);
        send_byte(8'hF0);
        reset_dut();
        #1;
        vectors++;
        if ({down0, ext0, code0, ascii0, cnt0} !== {1'b0, 1'b0, 8'h00, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL mid_reset got dn=%b ext=%b code=%h ascii=%h cnt=%h, required 0 0 00 00 00",
                     down0, ext0, code0, ascii0, cnt0);
        end
        send_byte(8'h1C);
        vectors++;
        if ({down0, code0, cnt0} !== {1'b1, 8'h1C, 8'h01}) begin
            miscompares++;
            $display("FAIL after_reset_make got dn=%b code=%h cnt=%h, required 1 1c 01",
                     down0, code0, cnt0);
        end
    endtask

    task automatic test_overflow();
        reset_dut();
        @(negedge clk);
        vectors++;
        if (ovf0 !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear got ovf=%b, required 0", ovf0);
        end
        kb_overflow = 1'b1;
        @(negedge clk);
        kb_overflow = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (ovf0 !== 1'b1 || ovf1 !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky got ovf0=%b ovf1=%b, required 1 1", ovf0, ovf1);
        end
        reset_dut();
        #1;
        vectors++;
        if (ovf0 !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_reset got ovf=%b, required 0", ovf0);
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_typematic();
        test_extended();
        test_second_key();
        test_bcd_wrap();
        test_back_to_back();
        test_mid_reset();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule
